// File: rtl/btime_pkg.sv
// Shared types and constants for the ROM download controller.
package btime_pkg;

  localparam int unsigned BTIME_ROM_SIZE = 61440;
  localparam int unsigned BTIME_ADDR_W   = 17;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDrain,
    StHold,
    StRun,
    StErr
  } dl_state_t;

  typedef struct packed {
    logic [BTIME_ADDR_W-1:0] addr;
    logic [7:0]              data;
  } fifo_entry_t;

endpackage

// File: rtl/dl_fifo2.sv
// Two-entry FIFO with fall-through when empty and push-while-full-with-pop.
module dl_fifo2
  import btime_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  fifo_entry_t wdata_i,
  input  logic        pop_en_i,
  output logic        space_o,
  output logic        pop_o,
  output fifo_entry_t rdata_o,
  output logic        empty_o,
  output logic [1:0]  occ_next_o
);

  logic [1:0]  occ_q, occ_d;
  logic        rd_ptr_q, wr_ptr_q;
  fifo_entry_t mem_q [2];
  logic        bypass, do_wr, do_rd;

  assign empty_o = (occ_q == 2'd0);
  assign space_o = (occ_q != 2'd2) || pop_en_i;
  // An empty FIFO hands an incoming byte straight to the reader.
  assign pop_o   = pop_en_i && (!empty_o || push_i);
  assign bypass  = empty_o && push_i && pop_en_i;
  assign do_wr   = push_i && !bypass;
  assign do_rd   = pop_o && !empty_o;
  assign rdata_o = empty_o ? wdata_i : mem_q[rd_ptr_q];

  always_comb begin
    occ_d = occ_q;
    if (do_wr && !do_rd) begin
      occ_d = occ_q + 2'd1;
    end else if (do_rd && !do_wr) begin
      occ_d = occ_q - 2'd1;
    end
  end

  assign occ_next_o = occ_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q    <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      if (do_rd) rd_ptr_q <= ~rd_ptr_q;
      if (do_wr) wr_ptr_q <= ~wr_ptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/rom_dl_ctrl.sv
// Sequences the HPS ROM download into the core's ROM port and gates core reset
// until a complete, correctly sized image has been written.
module rom_dl_ctrl
  import btime_pkg::*;
#(
  parameter int unsigned ROM_SIZE    = BTIME_ROM_SIZE,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned ADDR_W      = BTIME_ADDR_W
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  input  logic              dn_busy,
  output logic              core_reset,
  output logic              rom_loaded,
  output logic              rom_err
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  dl_state_t         state_q, state_d;
  logic [17:0]       count_q, count_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic              err_q, err_d;
  logic              wait_q, wait_d;
  logic              dn_wr_q, dn_wr_d;
  logic [ADDR_W-1:0] dn_addr_q, dn_addr_d;
  logic [7:0]        dn_data_q, dn_data_d;
  logic              core_reset_q, core_reset_d;
  logic              rom_loaded_q, rom_loaded_d;
  logic              rom_err_q, rom_err_d;

  logic        wr_req, accept, in_range, push, pop_en;
  logic        fifo_space, fifo_pop, fifo_empty;
  logic [1:0]  fifo_occ_next;
  fifo_entry_t wr_entry, rd_entry;

  assign pop_en   = ((state_q == StLoad) || (state_q == StDrain)) && !dn_busy;
  assign wr_req   = (state_q == StLoad) && ioctl_wr;
  assign accept   = wr_req && fifo_space;
  assign in_range = ioctl_addr < 25'(ROM_SIZE);
  assign push     = accept && in_range;
  assign wr_entry = '{addr: ioctl_addr[ADDR_W-1:0], data: ioctl_dout};

  dl_fifo2 u_fifo (
    .clk_i      (clk_sys),
    .rst_ni     (reset_n),
    .push_i     (push),
    .wdata_i    (wr_entry),
    .pop_en_i   (pop_en),
    .space_o    (fifo_space),
    .pop_o      (fifo_pop),
    .rdata_o    (rd_entry),
    .empty_o    (fifo_empty),
    .occ_next_o (fifo_occ_next)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hold_d    = hold_q;
    err_d     = err_q;
    rom_err_d = rom_err_q;
    unique case (state_q)
      StIdle: if (ioctl_download) state_d = StLoad;
      StLoad: begin
        if (accept && (count_q != '1)) count_d = count_q + 18'd1;
        // Sticky: a dropped byte or an out-of-range address spoils the image.
        if ((wr_req && !fifo_space) || (accept && !in_range)) err_d = 1'b1;
        if (!ioctl_download) state_d = StDrain;
      end
      StDrain: begin
        if (fifo_empty) begin
          state_d = ((count_q == 18'(ROM_SIZE)) && !err_q) ? StHold : StErr;
        end
      end
      StHold: begin
        if (ioctl_download) begin
          state_d = StLoad;
        end else if (hold_q == HoldW'(HOLD_CYCLES - 1)) begin
          state_d = StRun;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StRun, StErr: if (ioctl_download) state_d = StLoad;
      default: state_d = StIdle;
    endcase

    if ((state_d == StLoad) && (state_q != StLoad)) begin
      count_d   = '0;
      err_d     = 1'b0;
      rom_err_d = 1'b0;
    end
    if (state_d != StHold) hold_d = '0;
    if (state_d == StErr) rom_err_d = 1'b1;

    dn_wr_d      = fifo_pop;
    dn_addr_d    = fifo_pop ? rd_entry.addr : dn_addr_q;
    dn_data_d    = fifo_pop ? rd_entry.data : dn_data_q;
    wait_d       = (fifo_occ_next == 2'd2);
    core_reset_d = (state_d != StRun);
    rom_loaded_d = (state_d == StRun);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      count_q      <= '0;
      hold_q       <= '0;
      err_q        <= 1'b0;
      wait_q       <= 1'b0;
      dn_wr_q      <= 1'b0;
      dn_addr_q    <= '0;
      dn_data_q    <= '0;
      core_reset_q <= 1'b1;
      rom_loaded_q <= 1'b0;
      rom_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      hold_q       <= hold_d;
      err_q        <= err_d;
      wait_q       <= wait_d;
      dn_wr_q      <= dn_wr_d;
      dn_addr_q    <= dn_addr_d;
      dn_data_q    <= dn_data_d;
      core_reset_q <= core_reset_d;
      rom_loaded_q <= rom_loaded_d;
      rom_err_q    <= rom_err_d;
    end
  end

  assign ioctl_wait = wait_q;
  assign dn_wr      = dn_wr_q;
  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign core_reset = core_reset_q;
  assign rom_loaded = rom_loaded_q;
  assign rom_err    = rom_err_q;

endmodule
